// File: rtl/video_pkg.sv
// Shared types and constants for the video compositor and layer generators.
package video_pkg;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t TRANSPARENT_RGB = 12'h000;
  localparam int LEVEL_BITS = 4;
  localparam logic [LEVEL_BITS-1:0] LEVEL_FULL = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } fade_state_t;

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised-depth shift register with a configurable reset value, used to
// realign timing signals with the layer generators' pipeline delay.
module sync_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/video_compositor.sv
// Final display stage: realigns sync/blank, merges three RGB444 layers by
// priority and applies a frame-synchronous global brightness fade.
module video_compositor
  import video_pkg::*;
#(
  parameter int SYNC_DELAY       = 4,
  parameter int FADE_STEP_FRAMES = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [11:0] bg_pixel_in,
  input  logic [11:0] board_pixel_in,
  input  logic [11:0] overlay_pixel_in,
  input  logic        fade_req_in,
  input  logic        fade_dir_in,
  output logic        fade_busy_out,
  output logic [3:0]  level_out,
  output logic [11:0] rgb_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int CNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_FRAMES - 1);

  function automatic rgb444_t select_layer(input rgb444_t overlay, input rgb444_t board,
                                           input rgb444_t bg);
    if (overlay != TRANSPARENT_RGB)    return overlay;
    else if (board != TRANSPARENT_RGB) return board;
    else                               return bg;
  endfunction

  // Per-channel (c * level) >> 3 with truncation; level 8 is unity gain.
  function automatic rgb444_t scale_rgb(input rgb444_t pix, input logic [LEVEL_BITS-1:0] lvl);
    logic [7:0] prod;
    scale_rgb = '0;
    for (int ch = 0; ch < 3; ch++) begin
      prod = {4'b0, pix[ch*4 +: 4]} * {4'b0, lvl};
      scale_rgb[ch*4 +: 4] = 4'(prod >> 3);
    end
  endfunction

  logic [2:0] sync_p0;
  logic       hsync_p0, vsync_p0, blank_p0;
  logic       hsync_p1, vsync_p1, blank_p1;
  rgb444_t    pix_p1;
  logic       vsync_prev;
  logic       frame_tick;

  fade_state_t             state;
  logic [LEVEL_BITS-1:0]   level;
  logic [CNT_W-1:0]        frame_cnt;

  sync_delay_line #(
    .DEPTH     (SYNC_DELAY),
    .WIDTH     (3),
    .RESET_VAL (3'b111)
  ) u_sync_dly (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        ({hsync_in, vsync_in, blank_in}),
    .q        (sync_p0)
  );

  assign {hsync_p0, vsync_p0, blank_p0} = sync_p0;
  assign frame_tick = vsync_prev & ~vsync_p0;
  assign level_out  = level;

  // Stage 1: layer priority select, timing signals follow
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hsync_p1   <= 1'b1;
      vsync_p1   <= 1'b1;
      blank_p1   <= 1'b1;
      vsync_prev <= 1'b1;
      pix_p1     <= TRANSPARENT_RGB;
    end else begin
      hsync_p1   <= hsync_p0;
      vsync_p1   <= vsync_p0;
      blank_p1   <= blank_p0;
      vsync_prev <= vsync_p0;
      pix_p1     <= select_layer(overlay_pixel_in, board_pixel_in, bg_pixel_in);
    end
  end

  // Stage 2: brightness scaling and blanking
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      rgb_out   <= '0;
    end else begin
      hsync_out <= hsync_p1;
      vsync_out <= vsync_p1;
      rgb_out   <= blank_p1 ? 12'h000 : scale_rgb(pix_p1, level);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      level         <= LEVEL_FULL;
      frame_cnt     <= '0;
      fade_busy_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fade_req_in && fade_dir_in && level != '0) begin
            state         <= FADE_OUT;
            frame_cnt     <= '0;
            fade_busy_out <= 1'b1;
          end else if (fade_req_in && !fade_dir_in && level < LEVEL_FULL) begin
            state         <= FADE_IN;
            frame_cnt     <= '0;
            fade_busy_out <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
              frame_cnt <= '0;
              level     <= level - 1'b1;
              if (level == 4'd1) begin
                state         <= IDLE;
                fade_busy_out <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        FADE_IN: begin
          if (frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
              frame_cnt <= '0;
              level     <= level + 1'b1;
              if (level == LEVEL_FULL - 4'd1) begin
                state         <= IDLE;
                fade_busy_out <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: begin
          state         <= IDLE;
          fade_busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_compositor.sv
// Directed bench for video_compositor with a cycle-history reference model.
module tb_video_compositor;

  localparam int D  = 4;
  localparam int F  = 2;
  localparam int HN = 4096;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        hsync_in, vsync_in, blank_in;
  logic [11:0] bg_pixel_in, board_pixel_in, overlay_pixel_in;
  logic        fade_req_in, fade_dir_in;
  logic        fade_busy_out;
  logic [3:0]  level_out;
  logic [11:0] rgb_out;
  logic        hsync_out, vsync_out;

  video_compositor #(.SYNC_DELAY(D), .FADE_STEP_FRAMES(F)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .hsync_in         (hsync_in),
    .vsync_in         (vsync_in),
    .blank_in         (blank_in),
    .bg_pixel_in      (bg_pixel_in),
    .board_pixel_in   (board_pixel_in),
    .overlay_pixel_in (overlay_pixel_in),
    .fade_req_in      (fade_req_in),
    .fade_dir_in      (fade_dir_in),
    .fade_busy_out    (fade_busy_out),
    .level_out        (level_out),
    .rgb_out          (rgb_out),
    .hsync_out        (hsync_out),
    .vsync_out        (vsync_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model: input history per cycle plus fade progress in frames.
  logic        h_h [HN];
  logic        v_h [HN];
  logic        b_h [HN];
  logic [11:0] ov_h [HN];
  logic [11:0] bd_h [HN];
  logic [11:0] bg_h [HN];
  int          lvl_h [HN];

  int m_level = 8;
  bit m_fading = 0;
  bit m_dir = 0;
  int m_start = 8;
  int m_ticks = 0;

  function automatic logic hv(int i); return (i < base) ? 1'b1 : h_h[i]; endfunction
  function automatic logic vv(int i); return (i < base) ? 1'b1 : v_h[i]; endfunction
  function automatic logic bv(int i); return (i < base) ? 1'b1 : b_h[i]; endfunction

  function automatic logic [11:0] model_rgb(int c);
    logic [11:0] pix, res;
    int lvl, ch_val;
    if (c - 2 < base || bv(c - D - 2)) return 12'h000;
    if (ov_h[c-2] != 0)      pix = ov_h[c-2];
    else if (bd_h[c-2] != 0) pix = bd_h[c-2];
    else                     pix = bg_h[c-2];
    lvl = (c - 1 < base) ? 8 : lvl_h[c-1];
    res = '0;
    for (int k = 0; k < 3; k++) begin
      ch_val = ((int'(pix) >> (4 * k)) & 15) * lvl / 8;
      res = res | 12'(ch_val << (4 * k));
    end
    return res;
  endfunction

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      m_level = 8; m_fading = 0; m_ticks = 0;
    end else if (cyc < HN) begin
      h_h[cyc] = hsync_in; v_h[cyc] = vsync_in; b_h[cyc] = blank_in;
      ov_h[cyc] = overlay_pixel_in; bd_h[cyc] = board_pixel_in; bg_h[cyc] = bg_pixel_in;
      lvl_h[cyc] = m_level;
      chk("hsync", {11'b0, hsync_out}, {11'b0, hv(cyc - D - 2)});
      chk("vsync", {11'b0, vsync_out}, {11'b0, vv(cyc - D - 2)});
      chk("rgb", rgb_out, model_rgb(cyc));
      chk("level", {8'b0, level_out}, 12'(m_level));
      chk("busy", {11'b0, fade_busy_out}, {11'b0, m_fading});
      if (!m_fading) begin
        if (fade_req_in && ((fade_dir_in && m_level > 0) || (!fade_dir_in && m_level < 8))) begin
          m_fading = 1; m_dir = fade_dir_in; m_start = m_level; m_ticks = 0;
        end
      end else if (vv(cyc - D - 1) && !vv(cyc - D)) begin
        m_ticks++;
        m_level = m_dir ? m_start - m_ticks / F : m_start + m_ticks / F;
        if ((m_dir && m_level == 0) || (!m_dir && m_level == 8)) m_fading = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic frame();
    for (int i = 0; i < 20; i++) begin
      hsync_in = (i == 0) ? 1'b0 : 1'b1;
      vsync_in = (i == 2 || i == 3) ? 1'b0 : 1'b1;
      blank_in = (i < 5) ? 1'b1 : 1'b0;
      step();
    end
  endtask

  task automatic request(input logic dir);
    fade_req_in = 1'b1; fade_dir_in = dir;
    step();
    fade_req_in = 1'b0;
  endtask

  int t0;

  initial begin
    rst_n_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    bg_pixel_in = '0; board_pixel_in = '0; overlay_pixel_in = '0;
    fade_req_in = 1'b0; fade_dir_in = 1'b0;
    repeat (3) step();
    rst_n_in = 1'b1;
    base = cyc;

    for (int i = 0; i < 6; i++) begin
      chk("rst_rgb", rgb_out, 12'h000);
      chk("rst_hsync", {11'b0, hsync_out}, 12'h001);
      chk("rst_vsync", {11'b0, vsync_out}, 12'h001);
      chk("rst_level", {8'b0, level_out}, 12'h008);
      chk("rst_busy", {11'b0, fade_busy_out}, 12'h000);
      step();
    end

    bg_pixel_in = 12'hFFF;
    t0 = cyc;
    hsync_in = 1'b0;
    repeat (3) step();
    hsync_in = 1'b1;
    repeat (2) step();
    chk("hs_before", {11'b0, hsync_out}, 12'h001);
    step();
    chk("hs_low_first", {11'b0, hsync_out}, 12'h000);
    chk("blank_rgb", rgb_out, 12'h000);
    repeat (2) step();
    chk("hs_low_last", {11'b0, hsync_out}, 12'h000);
    step();
    chk("hs_after", {11'b0, hsync_out}, 12'h001);

    blank_in = 1'b0;
    overlay_pixel_in = 12'h000; board_pixel_in = 12'h17D; bg_pixel_in = 12'hD00;
    repeat (8) step();
    chk("prio_board", rgb_out, 12'h17D);
    overlay_pixel_in = 12'hFFF;
    repeat (2) step();
    chk("prio_overlay", rgb_out, 12'hFFF);
    overlay_pixel_in = 12'h000; board_pixel_in = 12'h000;
    repeat (2) step();
    chk("prio_bg", rgb_out, 12'hD00);

    bg_pixel_in = 12'hFFF;
    request(1'b1);
    chk("fo_busy", {11'b0, fade_busy_out}, 12'h001);
    repeat (2) frame();
    chk("fo_level7", {8'b0, level_out}, 12'h007);
    chk("fo_rgb7", rgb_out, 12'hDDD);
    repeat (14) frame();
    chk("fo_level0", {8'b0, level_out}, 12'h000);
    chk("fo_rgb0", rgb_out, 12'h000);
    chk("fo_done", {11'b0, fade_busy_out}, 12'h000);

    request(1'b1);
    chk("ignored_req", {11'b0, fade_busy_out}, 12'h000);
    repeat (2) step();
    request(1'b0);
    chk("fi_busy", {11'b0, fade_busy_out}, 12'h001);
    request(1'b1);
    repeat (16) frame();
    chk("fi_level8", {8'b0, level_out}, 12'h008);
    chk("fi_rgb", rgb_out, 12'hFFF);
    chk("fi_done", {11'b0, fade_busy_out}, 12'h000);

    request(1'b1);
    repeat (10) frame();
    chk("mid_level3", {8'b0, level_out}, 12'h003);
    chk("mid_rgb", rgb_out, 12'h555);
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_level", {8'b0, level_out}, 12'h008);
    chk("async_busy", {11'b0, fade_busy_out}, 12'h000);
    chk("async_rgb", rgb_out, 12'h000);
    chk("async_hsync", {11'b0, hsync_out}, 12'h001);
    chk("async_vsync", {11'b0, vsync_out}, 12'h001);
    repeat (2) step();
    rst_n_in = 1'b1;
    base = cyc;
    repeat (3) frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
